// File: rtl/sm_alu_disp.sv
// Sign-magnitude add/subtract unit (two-stage pipeline) with a 4-digit
// multiplexed seven-segment driver showing a selected value as signed hex.
module sm_alu_disp #(
    parameter int N            = 8,
    parameter int REFRESH_BITS = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         load,
    input  logic [1:0]   disp_sel,
    output logic [N-1:0] result,
    output logic         ovf,
    output logic         done,
    output logic [3:0]   an,
    output logic [7:0]   sseg
);

    localparam int M = N - 1;

    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic         sub_reg;
    logic         load_reg;

    logic [N-1:0] result_reg;
    logic         ovf_reg;
    logic         done_reg;

    logic [REFRESH_BITS-1:0] refresh_reg;
    logic [3:0]              an_reg;
    logic [7:0]              sseg_reg;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sub_reg  <= 1'b0;
            load_reg <= 1'b0;
        end else begin
            load_reg <= load;
            if (load) begin
                a_reg   <= a;
                b_reg   <= b;
                sub_reg <= sub;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign-magnitude arithmetic on stage-1 contents
    // ------------------------------------------------------------------
    logic [M-1:0] ma;
    logic [M-1:0] mb;
    logic         sa;
    logic         sb;
    logic [M:0]   sum_full;
    logic [M-1:0] mag_next;
    logic         sign_next;
    logic         ovf_next;

    assign ma = a_reg[M-1:0];
    assign mb = b_reg[M-1:0];
    // A zero magnitude carries no sign, so -0 operands behave as +0.
    assign sa = a_reg[N-1] & (ma != '0);
    assign sb = (b_reg[N-1] ^ sub_reg) & (mb != '0);
    assign sum_full = {1'b0, ma} + {1'b0, mb};

    always_comb begin
        mag_next  = '0;
        sign_next = 1'b0;
        ovf_next  = 1'b0;
        if (sa == sb) begin
            mag_next  = sum_full[M-1:0];
            sign_next = sa;
            ovf_next  = sum_full[M];
        end else if (ma >= mb) begin
            mag_next  = ma - mb;
            sign_next = sa;
        end else begin
            mag_next  = mb - ma;
            sign_next = sb;
        end
        if (mag_next == '0) begin
            sign_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= load_reg;
            if (load_reg) begin
                result_reg <= {sign_next, mag_next};
                ovf_reg    <= ovf_next;
            end
        end
    end

    assign result = result_reg;
    assign ovf    = ovf_reg;
    assign done   = done_reg;

    // ------------------------------------------------------------------
    // Display value selection and digit split
    // ------------------------------------------------------------------
    logic [N-1:0] disp_value;
    logic [11:0]  mag12;
    logic [3:0]   hex_digit [3];
    logic         disp_neg;

    always_comb begin
        case (disp_sel)
            2'b00:   disp_value = a_reg;
            2'b01:   disp_value = b_reg;
            default: disp_value = result_reg;
        endcase
    end

    always_comb begin
        mag12        = '0;
        mag12[M-1:0] = disp_value[M-1:0];
    end

    assign disp_neg = disp_value[N-1] & (mag12 != '0);

    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
        assign hex_digit[gi] = mag12[4*gi +: 4];
    end

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        case (d)
            4'h0:    hex_glyph = 7'h01;
            4'h1:    hex_glyph = 7'h4F;
            4'h2:    hex_glyph = 7'h12;
            4'h3:    hex_glyph = 7'h06;
            4'h4:    hex_glyph = 7'h4C;
            4'h5:    hex_glyph = 7'h24;
            4'h6:    hex_glyph = 7'h20;
            4'h7:    hex_glyph = 7'h0F;
            4'h8:    hex_glyph = 7'h00;
            4'h9:    hex_glyph = 7'h04;
            4'hA:    hex_glyph = 7'h08;
            4'hB:    hex_glyph = 7'h60;
            4'hC:    hex_glyph = 7'h31;
            4'hD:    hex_glyph = 7'h42;
            4'hE:    hex_glyph = 7'h30;
            default: hex_glyph = 7'h38;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Scan: digit index from the top two refresh bits
    // ------------------------------------------------------------------
    logic [1:0] digit_idx;
    logic [3:0] an_next;
    logic [7:0] sseg_next;

    assign digit_idx = refresh_reg[REFRESH_BITS-1 -: 2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_an
        assign an_next[gi] = (digit_idx != 2'(gi));
    end

    always_comb begin
        sseg_next = 8'hFF;
        case (digit_idx)
            2'd0: sseg_next = {1'b1, hex_glyph(hex_digit[0])};
            2'd1: begin
                if (hex_digit[1] != 4'h0 || hex_digit[2] != 4'h0) begin
                    sseg_next = {1'b1, hex_glyph(hex_digit[1])};
                end
            end
            2'd2: begin
                if (hex_digit[2] != 4'h0) begin
                    sseg_next = {1'b1, hex_glyph(hex_digit[2])};
                end
            end
            default: sseg_next = {~(disp_sel[1] & ovf_reg), 6'b111111, ~disp_neg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_reg <= '0;
            an_reg      <= 4'b1111;
            sseg_reg    <= 8'hFF;
        end else begin
            refresh_reg <= refresh_reg + 1'b1;
            an_reg      <= an_next;
            sseg_reg    <= sseg_next;
        end
    end

    assign an   = an_reg;
    assign sseg = sseg_reg;

endmodule

// File: tb/tb_sm_alu_disp.sv
// Directed bench for sm_alu_disp (N=8, REFRESH_BITS=4): arithmetic vector
// table plus hand-written scan, pipelining and reset sequences.
module tb_sm_alu_disp;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       load;
    logic [1:0] disp_sel;
    logic [7:0] result;
    logic       ovf;
    logic       done;
    logic [3:0] an;
    logic [7:0] sseg;

    always #5 clk = ~clk;

    sm_alu_disp #(.N(8), .REFRESH_BITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .load     (load),
        .disp_sel (disp_sel),
        .result   (result),
        .ovf      (ovf),
        .done     (done),
        .an       (an),
        .sseg     (sseg)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       ovf;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         shown    = -1;
    logic [3:0] cnt_model = 4'd0;
    vec_t       vecs [12];

    // Advance one edge; track which digit the scan output should be showing.
    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) begin
            cnt_model = 4'd0;
            shown     = -1;
        end else begin
            shown     = int'(cnt_model[3:2]);
            cnt_model = cnt_model + 4'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_an();
        if (shown < 0) return 4'b1111;
        return ~(4'b0001 << shown);
    endfunction

    // Four edges; each checks enables and the segment pattern of the shown digit.
    task automatic check_scan(input string name, input logic [31:0] segs);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({name, "_an"}, {28'd0, an}, {28'd0, exp_an()});
            chk({name, "_sseg"}, {24'd0, sseg}, {24'd0, segs[8*shown +: 8]});
        end
        $display("scan %s: checked 4 digits", name);
    endtask

    initial begin
        vecs[0]  = '{8'h05, 8'h83, 1'b0, 8'h02, 1'b0};
        vecs[1]  = '{8'h85, 8'h05, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{8'h80, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{8'h03, 8'h10, 1'b1, 8'h8D, 1'b0};
        vecs[5]  = '{8'h81, 8'h81, 1'b0, 8'h82, 1'b0};
        vecs[6]  = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b0};
        vecs[7]  = '{8'h7F, 8'h7F, 1'b0, 8'h7E, 1'b1};
        vecs[8]  = '{8'hFF, 8'h7F, 1'b1, 8'hFE, 1'b1};
        vecs[9]  = '{8'h10, 8'h90, 1'b1, 8'h20, 1'b0};
        vecs[10] = '{8'h85, 8'h03, 1'b1, 8'h88, 1'b0};
        vecs[11] = '{8'h02, 8'h85, 1'b0, 8'h83, 1'b0};

        reset = 1'b1; load = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; disp_sel = 2'b00;
        tick();
        tick();
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_sseg", {24'd0, sseg}, 32'hFF);
        chk("rst_result", {24'd0, result}, 32'h0);
        chk("rst_ovf", {31'd0, ovf}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        reset = 1'b0;
        tick();
        chk("rel_an", {28'd0, an}, 32'hE);
        $display("reset: initial state checked");

        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; load = 1'b1;
            tick();
            chk("vec_done_early", {31'd0, done}, 32'h0);
            load = 1'b0;
            tick();
            chk("vec_result", {24'd0, result}, {24'd0, vecs[i].res});
            chk("vec_ovf", {31'd0, ovf}, {31'd0, vecs[i].ovf});
            chk("vec_done", {31'd0, done}, 32'h1);
            tick();
            chk("vec_done_pulse", {31'd0, done}, 32'h0);
            $display("vec %0d: a=%h b=%h sub=%0d -> result=%h ovf=%0d", i, vecs[i].a,
                     vecs[i].b, vecs[i].sub, result, ovf);
        end

        // Overflowed zero result: dp lit, sign blank on digit 3.
        a = 8'h7F; b = 8'h01; sub = 1'b0; disp_sel = 2'b10; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        check_scan("ovf_disp", {8'h7F, 8'hFF, 8'hFF, 8'h81});

        // Source selection and leading-zero blanking.
        a = 8'h85; b = 8'h7F; sub = 1'b0; disp_sel = 2'b00; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_scan("disp_a", {8'hFE, 8'hFF, 8'hFF, 8'hA4});
        disp_sel = 2'b01;
        tick();
        check_scan("disp_b", {8'hFF, 8'hFF, 8'h8F, 8'hB8});
        disp_sel = 2'b11;
        tick();
        check_scan("disp_res", {8'hFF, 8'hFF, 8'h8F, 8'h88});

        // 3 - 0x10 = -0xD over two full scan rotations.
        a = 8'h03; b = 8'h10; sub = 1'b1; disp_sel = 2'b10; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("sub_result", {24'd0, result}, 32'h8D);
        tick();
        check_scan("sub_disp0", {8'hFE, 8'hFF, 8'hFF, 8'hC2});
        check_scan("sub_disp1", {8'hFE, 8'hFF, 8'hFF, 8'hC2});

        // Back-to-back loads.
        sub = 1'b0;
        a = 8'h01; b = 8'h02; load = 1'b1;
        tick();
        chk("pipe_done0", {31'd0, done}, 32'h0);
        a = 8'h81; b = 8'h01;
        tick();
        chk("pipe_done1", {31'd0, done}, 32'h1);
        chk("pipe_res1", {24'd0, result}, 32'h03);
        a = 8'h03; b = 8'h83;
        tick();
        load = 1'b0;
        chk("pipe_done2", {31'd0, done}, 32'h1);
        chk("pipe_res2", {24'd0, result}, 32'h00);
        tick();
        chk("pipe_done3", {31'd0, done}, 32'h1);
        chk("pipe_res3", {24'd0, result}, 32'h00);
        tick();
        chk("pipe_done4", {31'd0, done}, 32'h0);
        $display("pipeline: three back-to-back loads checked");

        // Reset mid-pipeline and mid-scan.
        a = 8'h05; b = 8'h01; load = 1'b1;
        tick();
        tick();
        chk("pre_rst_result", {24'd0, result}, 32'h06);
        a = 8'h07; b = 8'h07; reset = 1'b1;
        tick();
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_sseg", {24'd0, sseg}, 32'hFF);
        chk("mid_rst_result", {24'd0, result}, 32'h0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'h0);
        chk("mid_rst_done", {31'd0, done}, 32'h0);
        reset = 1'b0; load = 1'b0;
        tick();
        chk("mid_rel_an", {28'd0, an}, 32'hE);
        chk("mid_rel_done", {31'd0, done}, 32'h0);
        chk("mid_rel_result", {24'd0, result}, 32'h0);
        tick();
        chk("mid_rel_done2", {31'd0, done}, 32'h0);
        $display("reset: mid-pipeline reset checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_alu_disp.md
# sm_alu_disp

Parametrised sign-magnitude add/subtract unit with an integrated 4-digit seven-segment display driver. It registers two N-bit sign-magnitude operands on a load strobe and produces a registered result with an overflow flag. It continuously scans a selected value (operand A, operand B or result) onto a time-multiplexed display as a signed hex number. It sits between board switches/buttons and the seven-segment LEDs and replaces the combinational adder test harness of earlier chapters.

## Interface
- `N`, default 8: operand/result width; MSB is sign, `N-1` magnitude bits; legal range 2..13, so the magnitude fits in at most 3 hex digits.
- `REFRESH_BITS`, default 18: width of the display refresh counter; legal minimum 3.

- `clk`  in  1  system clock; the block has one clock, all state is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  N  operand A, sign-magnitude.
- `b`  in  N  operand B, sign-magnitude.
- `sub`  in  1  0 = A+B, 1 = A−B; captured with the operands.
- `load`  in  1  capture strobe; one capture per cycle while high.
- `disp_sel`  in  2  display source: 00 = latched A, 01 = latched B, 1x = result.
- `result`  out  N  registered sign-magnitude result.
- `ovf`  out  1  registered magnitude overflow of `result`.
- `done`  out  1  one-cycle pulse when `result`/`ovf` update.
- `an`  out  4  digit enables, active-low, `an[0]` = rightmost digit.
- `sseg`  out  8  segments, active-low, `sseg[7]` = dp, `sseg[6:0]` = {a,b,c,d,e,f,g}.

## Operation
- Stage 1: on `load`=1 at edge k, register `a`, `b` and `sub` into `a_q`, `b_q`, `sub_q`. A `load` valid flag is also registered.
- Stage 2: at edge k+1, register `result`, `ovf` and `done`=1 from stage-1 contents. `done`=0 in every other cycle.
- Back-to-back `load` is fully pipelined, giving one result per cycle.
- Effective B sign is `b_q[N-1] ^ sub_q`.
- Same effective signs: magnitude = `ma+mb` truncated to N-1 bits, sign = A sign, `ovf` = carry out.
- Different signs: magnitude = larger − smaller, sign = sign of the larger magnitude, `ovf`=0.
- Zero normalisation: a zero magnitude always yields sign 0, so −0 is never output. Operands with −0 are treated as zero.
- Display value V comes from `disp_sel`, sampled every cycle. Its magnitude splits into hex digits d2, d1, d0; digits above N-1 bits are zero.
- Digit 3 shows `-` (segment g only) when V is negative, otherwise blank. Its dp is lit when `disp_sel`=1x and `ovf`=1.
- Digit 2 and digit 1 use leading-zero blanking: a digit is blank when it and all higher magnitude digits are zero.
- Digit 0 is always shown. dp on digits 0–2 is always off.
- Hex glyphs use standard 0–F patterns. A blank digit drives `sseg`=8'hFF.
- Scan: a free-running `REFRESH_BITS` counter whose top 2 bits select digit index 0,1,2,3 in order. Each digit is held for 2^(REFRESH_BITS-2) cycles, and the counter wraps silently.

## Timing
- Reset values, applied at the next edge with `reset`=1:
  - `a_q`, `b_q`, `sub_q`, `result` = 0; `ovf`=0; `done`=0.
  - Refresh counter = 0; `an`=4'b1111; `sseg`=8'hFF.
- `reset` has priority over `load`. A load in the reset cycle is discarded, and a load pending in stage 1 when reset asserts produces no `done`.
- Latency: `load` at edge k → `result`/`done` valid after edge k+1.
- `an` and `sseg` are registered from the counter and V: one cycle of latency relative to the counter.
  - The first edge after reset release drives `an`=4'b1110.
  - A `disp_sel` or `result` change appears on `sseg` one edge later.
- `an` never has more than one zero bit.

## Test plan
- **Reset:** assert `reset` mid-scan and mid-pipeline → next edge `an`=1111, `sseg`=FF, `result`=0, `ovf`=0, `done`=0; release → next edge `an`=1110.
- **Mixed signs (N=8):** `a`=8'h05, `b`=8'h83, `sub`=0, `load` 1 cycle → two edges later `result`=8'h02, `ovf`=0, `done` high exactly 1 cycle.
- **Zero normalisation:** `a`=8'h85, `b`=8'h05, add → `result`=8'h00, not 8'h80. Also `a`=8'h80, `b`=8'h00 → 8'h00.
- **Overflow:** `a`=8'h7F, `b`=8'h01, add → `result`=8'h00, `ovf`=1. With `disp_sel`=10, digit 3 shows `sseg`=8'b0111_1111 (dp lit, sign blank).
- **Subtract and display (REFRESH_BITS=4):** `a`=8'h03, `b`=8'h10, `sub`=1 → `result`=8'h8D. Scan shows:
  - digit 0 = `d` glyph;
  - digits 1 and 2 = 8'hFF;
  - digit 3 = 8'b1111_1110.
  - `an` cycles 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
- **Pipelining:** `load` high 3 consecutive cycles with operand pairs (1,2), (8'h81,1), (3,8'h83) add → `done` high 3 consecutive cycles, with `result` = 8'h03, 8'h00, 8'h00 in order.
